// File: rtl/merge_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | merge_sched_pkg                                                            |
// | Shared state encoding, descriptor width offsets and min helper for the     |
// | bottom-up merge sort pass scheduler.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package merge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Descriptor fields are ADDR_W+LEN_EXTRA_W wide so they can hold 2^ADDR_W;
  // the running base needs one more bit so base + 2*run_len never wraps.
  localparam int unsigned LEN_EXTRA_W  = 1;
  localparam int unsigned BASE_EXTRA_W = 2;

  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/merge_run_calc.sv
// +----------------------------------------------------------------------------+
// | merge_run_calc                                                             |
// | Combinational two-run descriptor: clips both runs to the buffer end.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module merge_run_calc
  import merge_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W+BASE_EXTRA_W-1:0] base,
  input  logic [ADDR_W+BASE_EXTRA_W-1:0] run_len,
  input  logic [ADDR_W+LEN_EXTRA_W-1:0]  n_total,
  output logic [ADDR_W+LEN_EXTRA_W-1:0]  a_len,
  output logic [ADDR_W+LEN_EXTRA_W-1:0]  b_base,
  output logic [ADDR_W+LEN_EXTRA_W-1:0]  b_len
);

  localparam int unsigned BW = ADDR_W + BASE_EXTRA_W;
  localparam int unsigned LW = ADDR_W + LEN_EXTRA_W;

  logic [BW-1:0] w_n;
  logic [BW-1:0] w_rem_a;
  logic [BW-1:0] w_a_len;
  logic [BW-1:0] w_b_base;
  logic [BW-1:0] w_rem_b;

  always_comb begin
    w_n      = BW'(n_total);
    w_rem_a  = (base < w_n) ? (w_n - base) : '0;
    w_a_len  = BW'(min_u(32'(run_len), 32'(w_rem_a)));
    w_b_base = base + w_a_len;
    w_rem_b  = (w_b_base < w_n) ? (w_n - w_b_base) : '0;
    a_len    = LW'(w_a_len);
    b_base   = LW'(w_b_base);
    // A missing B run turns the command into a plain copy of A.
    b_len    = (w_b_base >= w_n) ? '0 : LW'(min_u(32'(run_len), 32'(w_rem_b)));
  end

endmodule

`default_nettype wire

// File: rtl/merge_sort_sched.sv
// +----------------------------------------------------------------------------+
// | merge_sort_sched                                                           |
// | Bottom-up merge sort pass scheduler driving one shared merge datapath.     |
// | Optional perf counters enabled by defining MERGE_SCHED_PERF_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module merge_sort_sched
  import merge_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     n_words,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [ADDR_W:0]     cmd_a_base,
  output logic [ADDR_W:0]     cmd_a_len,
  output logic [ADDR_W:0]     cmd_b_base,
  output logic [ADDR_W:0]     cmd_b_len,
  output logic                cmd_src_bank,
  input  logic                merge_done,
  output logic                busy,
  output logic                done,
  output logic                result_bank,
`ifdef MERGE_SCHED_PERF_EN
  output logic [CNT_W-1:0]    perf_cmds,
  output logic [CNT_W-1:0]    perf_busy_cycles,
`endif
  output logic [ADDR_W-1:0]   pass_idx
);

  localparam int unsigned BW = ADDR_W + BASE_EXTRA_W;
  localparam int unsigned LW = ADDR_W + LEN_EXTRA_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [LW-1:0]       r_n;
  logic [BW-1:0]       r_base;
  logic [BW-1:0]       r_run_len;
  logic                r_bank;
  logic [ADDR_W-1:0]   r_pass_idx;
  logic [LW-1:0]       r_a_base;
  logic [LW-1:0]       r_a_len;
  logic [LW-1:0]       r_b_base;
  logic [LW-1:0]       r_b_len;
  logic                r_src_bank;
  logic                r_result_bank;

  logic [LW-1:0]       w_a_len;
  logic [LW-1:0]       w_b_base;
  logic [LW-1:0]       w_b_len;
  logic [BW-1:0]       w_base_next;
  logic [BW-1:0]       w_run_len_next;
  logic                w_pass_end;
  logic                w_sort_end;

  merge_run_calc #(
    .ADDR_W (ADDR_W)
  ) u_run_calc (
    .base    (r_base),
    .run_len (r_run_len),
    .n_total (r_n),
    .a_len   (w_a_len),
    .b_base  (w_b_base),
    .b_len   (w_b_len)
  );

  always_comb begin
    w_state_next   = r_state;
    w_base_next    = r_base + {r_run_len[BW-2:0], 1'b0};
    w_run_len_next = {r_run_len[BW-2:0], 1'b0};
    w_pass_end     = (w_base_next >= BW'(r_n));
    w_sort_end     = (w_run_len_next >= BW'(r_n));

    case (r_state)
      IDLE:    if (start) w_state_next = (n_words <= LW'(1)) ? DONE : SETUP;
      SETUP:   w_state_next = ISSUE;
      ISSUE:   if (cmd_ready) w_state_next = WAIT;
      WAIT:    if (merge_done) w_state_next = (w_pass_end && w_sort_end) ? DONE : SETUP;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (abort) w_state_next = IDLE;

    cmd_valid    = (r_state == ISSUE);
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    cmd_a_base   = r_a_base;
    cmd_a_len    = r_a_len;
    cmd_b_base   = r_b_base;
    cmd_b_len    = r_b_len;
    cmd_src_bank = r_src_bank;
    result_bank  = r_result_bank;
    pass_idx     = r_pass_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_n           <= '0;
      r_base        <= '0;
      r_run_len     <= BW'(1);
      r_bank        <= 1'b0;
      r_pass_idx    <= '0;
      r_a_base      <= '0;
      r_a_len       <= '0;
      r_b_base      <= '0;
      r_b_len       <= '0;
      r_src_bank    <= 1'b0;
      r_result_bank <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!abort) begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_n        <= n_words;
              r_base     <= '0;
              r_run_len  <= BW'(1);
              r_bank     <= 1'b0;
              r_pass_idx <= '0;
              if (n_words <= LW'(1)) r_result_bank <= 1'b0;
            end
          end
          SETUP: begin
            r_a_base   <= LW'(r_base);
            r_a_len    <= w_a_len;
            r_b_base   <= w_b_base;
            r_b_len    <= w_b_len;
            r_src_bank <= r_bank;
          end
          WAIT: begin
            if (merge_done) begin
              if (w_pass_end) begin
                r_base     <= '0;
                r_run_len  <= w_run_len_next;
                r_bank     <= ~r_bank;
                r_pass_idx <= r_pass_idx + ADDR_W'(1);
                // Sorted data lands in the bank this last pass wrote.
                if (w_sort_end) r_result_bank <= ~r_bank;
              end else begin
                r_base <= w_base_next;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MERGE_SCHED_PERF_EN
  logic [CNT_W-1:0] r_perf_cmds;
  logic [CNT_W-1:0] r_perf_busy;
  logic             w_accept;
  logic             w_hs;

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_hs     = (r_state == ISSUE) && cmd_ready && !abort;

  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_perf_cmds <= '0;
      r_perf_busy <= '0;
    end else begin
      if (w_hs && (r_perf_cmds != '1)) r_perf_cmds <= r_perf_cmds + CNT_W'(1);
      if (busy && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + CNT_W'(1);
    end
  end

  assign perf_cmds        = r_perf_cmds;
  assign perf_busy_cycles = r_perf_busy;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_merge_sort_sched.sv
// +----------------------------------------------------------------------------+
// | tb_merge_sort_sched                                                        |
// | Self-checking bench: vector table plus scoreboard of expected commands.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_merge_sort_sched;

  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   n_words;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W:0]   cmd_a_base;
  logic [ADDR_W:0]   cmd_a_len;
  logic [ADDR_W:0]   cmd_b_base;
  logic [ADDR_W:0]   cmd_b_len;
  logic              cmd_src_bank;
  logic              merge_done;
  logic              busy;
  logic              done;
  logic              result_bank;
  logic [ADDR_W-1:0] pass_idx;
`ifdef MERGE_SCHED_PERF_EN
  logic [15:0]       perf_cmds;
  logic [15:0]       perf_busy_cycles;
`endif

  merge_sort_sched #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .n_words          (n_words),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_a_base       (cmd_a_base),
    .cmd_a_len        (cmd_a_len),
    .cmd_b_base       (cmd_b_base),
    .cmd_b_len        (cmd_b_len),
    .cmd_src_bank     (cmd_src_bank),
    .merge_done       (merge_done),
    .busy             (busy),
    .done             (done),
    .result_bank      (result_bank),
`ifdef MERGE_SCHED_PERF_EN
    .perf_cmds        (perf_cmds),
    .perf_busy_cycles (perf_busy_cycles),
`endif
    .pass_idx         (pass_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    int n;
    int exp_rb;
    int exp_pass;
    int exp_cmds;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_hs    = 0;
  int          n_done  = 0;
  int          n_vc    = 0;
  int          inject_cnt  = 0;
  int          inject_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e_cmd;

  function automatic logic [63:0] pack(input int ab, input int al, input int bb,
                                       input int bl, input int bank);
    return {12'd0, 4'(bank), 12'(ab), 12'(al), 12'(bb), 12'(bl)};
  endfunction

  function automatic logic [63:0] dut_cmd();
    return pack(int'(cmd_a_base), int'(cmd_a_len), int'(cmd_b_base), int'(cmd_b_len),
                int'(cmd_src_bank));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference command list straight from the merge-pass definition.
  task automatic gen_model(input int n);
    int bank = 0;
    for (int rl = 1; rl < n; rl = rl * 2) begin
      for (int b = 0; b < n; b = b + 2 * rl) begin
        int al = (rl < n - b) ? rl : n - b;
        int bb = b + al;
        int bl = (bb >= n) ? 0 : ((rl < n - bb) ? rl : n - bb);
        exp_q.push_back(pack(b, al, bb, bl, bank));
      end
      bank = 1 - bank;
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clock) begin
    if (cmd_valid) n_vc++;
    if (done) n_done++;
    if (cmd_valid && cmd_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cmd_extra: got 0x%0h, required no command", dut_cmd());
      end else begin
        e_cmd = exp_q.pop_front();
        check("cmd", dut_cmd(), e_cmd);
      end
    end
  end

  // Datapath model: merge_done three cycles after each handshake, or on request.
  initial begin
    merge_done = 1'b0;
    forever begin
      @(negedge clock);
      if (inject_cnt != inject_seen) begin
        inject_seen = inject_cnt;
        @(posedge clock); #1 merge_done = 1'b1;
        @(posedge clock); #1 merge_done = 1'b0;
      end else if (cmd_valid && cmd_ready) begin
        repeat (3) @(posedge clock);
        #1 merge_done = 1'b1;
        @(posedge clock); #1 merge_done = 1'b0;
      end
    end
  end

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_sort(input vec_t v);
    bit seen;
    exp_q.delete();
    gen_model(v.n);
    n_hs = 0; n_done = 0; n_vc = 0;
    @(posedge clock); #1 start = 1'b1; n_words = (ADDR_W+1)'(v.n);
    @(posedge clock); #1 start = 1'b0; n_words = 9'd3;
    @(negedge clock);
    if (v.n <= 1) begin
      check("done_latency", done, 1);
      seen = done;
    end else begin
      check("valid_early", cmd_valid, 0);
      @(negedge clock);
      check("valid_2cyc", cmd_valid, 1);
      wait_done(seen);
    end
    check("done_seen", seen, 1);
    repeat (2) @(negedge clock);
    check("done_pulses", n_done, 1);
    check("result_bank", result_bank, v.exp_rb);
    check("pass_idx", pass_idx, v.exp_pass);
    check("cmd_count", n_hs, v.exp_cmds);
    check("sb_empty", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    if (v.n <= 1) check("no_valid", n_vc, 0);
`ifdef MERGE_SCHED_PERF_EN
    check("perf_cmds", perf_cmds, v.exp_cmds);
    check("perf_busy_nz", (perf_busy_cycles != 0), 1);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v8;
    bit   seen;
    logic [63:0] cap;
    int   rb_before;

    vecs[0] = '{n: 8,   exp_rb: 1, exp_pass: 3, exp_cmds: 7};
    vecs[1] = '{n: 5,   exp_rb: 1, exp_pass: 3, exp_cmds: 6};
    vecs[2] = '{n: 0,   exp_rb: 0, exp_pass: 0, exp_cmds: 0};
    vecs[3] = '{n: 1,   exp_rb: 0, exp_pass: 0, exp_cmds: 0};
    vecs[4] = '{n: 2,   exp_rb: 1, exp_pass: 1, exp_cmds: 1};
    vecs[5] = '{n: 3,   exp_rb: 0, exp_pass: 2, exp_cmds: 3};
    vecs[6] = '{n: 7,   exp_rb: 1, exp_pass: 3, exp_cmds: 7};
    vecs[7] = '{n: 16,  exp_rb: 0, exp_pass: 4, exp_cmds: 15};
    vecs[8] = '{n: 256, exp_rb: 0, exp_pass: 8, exp_cmds: 255};
    v8 = vecs[0];

    reset = 1'b1; start = 1'b0; abort = 1'b0; n_words = '0; cmd_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result_bank", result_bank, 0);
    check("rst_pass_idx", pass_idx, 0);
    check("rst_fields", dut_cmd(), 0);

    for (int i = 0; i < 9; i++) run_sort(vecs[i]);

    // Backpressure in ISSUE with a stray merge_done.
    exp_q.delete(); gen_model(4);
    n_hs = 0; n_done = 0;
    cmd_ready = 1'b0;
    @(posedge clock); #1 start = 1'b1; n_words = 9'd4;
    @(posedge clock); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (cmd_valid) seen = 1'b1;
    end
    check("stall_valid_seen", seen, 1);
    cap = dut_cmd();
    check("stall_first_cmd", cap, pack(0, 1, 1, 1, 0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (i == 1) inject_cnt++;
      @(negedge clock);
      check("stall_valid", cmd_valid, 1);
      check("stall_fields", dut_cmd(), cap);
    end
    @(posedge clock); #1 cmd_ready = 1'b1;
    @(negedge clock);
    check("stall_hs_valid", cmd_valid, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("stall_wait_valid", cmd_valid, 0);
    check("stall_hs_count", n_hs, 1);
    wait_done(seen);
    check("stall_done", seen, 1);
    repeat (2) @(negedge clock);
    check("stall_rb", result_bank, 0);
    check("stall_cmds", n_hs, 3);
    check("stall_sb_empty", exp_q.size(), 0);

    // Abort in WAIT during pass 1 of N=16.
    run_sort(v8);
    exp_q.delete(); gen_model(16);
    @(posedge clock); #1 start = 1'b1; n_words = 9'd16;
    @(posedge clock); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clock);
      if (cmd_valid && cmd_ready && pass_idx == 8'd1) seen = 1'b1;
    end
    check("abort_pass1_seen", seen, 1);
    rb_before = int'(result_bank);
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_valid", cmd_valid, 0);
    check("abort_done", done, 0);
    check("abort_rb", result_bank, rb_before);
    check("abort_rb_prev", result_bank, 1);
    n_done = 0; n_vc = 0;
    repeat (6) @(negedge clock);
    check("abort_no_done", n_done, 0);
    check("abort_no_valid", n_vc, 0);
    exp_q.delete();
    run_sort('{n: 2, exp_rb: 1, exp_pass: 1, exp_cmds: 1});

    // Reset mid-operation.
    exp_q.delete(); gen_model(8);
    @(posedge clock); #1 start = 1'b1; n_words = 9'd8;
    @(posedge clock); #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mrst_busy", busy, 0);
    check("mrst_valid", cmd_valid, 0);
    check("mrst_rb", result_bank, 0);
    check("mrst_pass_idx", pass_idx, 0);
    check("mrst_fields", dut_cmd(), 0);
    exp_q.delete();
    repeat (8) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/merge_sort_sched.md
Name: merge_sort_sched

Overview:
Pass scheduler for a bottom-up merge sort built around one shared two-run merge datapath: the FIFO-pair merge stage plus its run read/write engine. For a buffer of n_words elements it issues merge commands for run lengths 1, 2, 4, … until one run covers the buffer. Each command names two source runs and the ping-pong source bank. It then waits for the datapath to finish before issuing the next command. It sits between the host control interface and the merge datapath.

Parameters:
ADDR_W, 8, element address width; maximum buffer size is 2^ADDR_W.
CNT_W, 16, width of the optional performance counters.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a sort; sampled only in IDLE
abort  input  1  synchronous abort; return to IDLE
n_words  input  ADDR_W+1  element count, 0..2^ADDR_W; latched on accepted start
cmd_valid  output  1  merge command valid
cmd_ready  input  1  datapath accepts command
cmd_a_base  output  ADDR_W+1  start index of run A
cmd_a_len  output  ADDR_W+1  length of run A (≥1)
cmd_b_base  output  ADDR_W+1  start index of run B (= a_base + a_len)
cmd_b_len  output  ADDR_W+1  length of run B; 0 means copy A only
cmd_src_bank  output  1  bank to read; datapath writes the other bank
merge_done  input  1  one-cycle pulse: current command complete
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the sort completes
result_bank  output  1  bank holding sorted data; valid after done
pass_idx  output  ADDR_W  current pass number, 0-based

Behaviour:
- Reset: state=IDLE; cmd_valid=0; all cmd_* fields=0; busy=0; done=0; result_bank=0; pass_idx=0. Internal base=0, run_len=1, bank=0.
- States: IDLE, SETUP, ISSUE, WAIT, DONE.
- IDLE: when start=1, latch N=n_words and set base=0, run_len=1, bank=0, pass_idx=0.
  - N≤1: go to DONE. No commands are issued and result_bank=0.
  - Otherwise: go to SETUP.
- SETUP: register the command descriptor, then go to ISSUE.
  - a_base=base.
  - a_len=min(run_len, N-base).
  - b_base=base+a_len.
  - b_len = (b_base≥N) ? 0 : min(run_len, N-b_base).
  - src_bank=bank.
- ISSUE: cmd_valid=1 and fields are held stable. Handshake occurs on the cycle where cmd_valid & cmd_ready; the next state is WAIT.
  - cmd_valid rises exactly 2 cycles after the start-accept cycle, or after the merge_done cycle.
- WAIT: cmd_valid=0. merge_done in any other state is ignored. On merge_done:
  - base ← base + 2·run_len, computed in ADDR_W+2 bits so there is no wrap.
  - If the new base < N: go to SETUP.
  - Else the pass ends: bank ← ~bank, run_len ← run_len<<1, pass_idx ← pass_idx+1, base ← 0.
    - If the new run_len ≥ N: go to DONE with result_bank ← new bank.
    - Otherwise: go to SETUP.
- DONE: done=1 for one cycle, then IDLE. result_bank holds until the next accepted start.
- start outside IDLE is ignored. A new n_words mid-sort has no effect.
- abort, in any state, forces IDLE on the next edge:
  - cmd_valid, busy and done drop to 0.
  - result_bank is not updated.
  - abort has priority over start, cmd_ready and merge_done in the same cycle.
- reset asserted mid-operation gives the same result as power-on reset.
- Arithmetic is unsigned. Commands issued per pass = ceil(N/(2·run_len)). Pass count = ceil(log2 N).

Optional Feature:
MERGE_SCHED_PERF_EN
- Defined: adds outputs perf_cmds (CNT_W) and perf_busy_cycles (CNT_W).
  - perf_cmds counts cmd handshakes.
  - perf_busy_cycles counts cycles with busy=1.
  - Both clear on accepted start and on reset.
  - Both saturate at all-ones.
  - Both hold their value after done or abort.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package merge_sched_pkg holds:
  - the state encoding constants (IDLE..DONE);
  - the command descriptor field widths derived from ADDR_W;
  - a min helper function.
- One sub-module, merge_run_calc: combinational descriptor calculation (a_len, b_base, b_len from base, run_len, N), instantiated by the FSM and registered in SETUP.

Test Plan:
- N=8, cmd_ready tied 1, merge_done 3 cycles after each handshake:
  - Command (a_base,a_len,b_base,b_len) order: (0,1,1,1) (2,1,3,1) (4,1,5,1) (6,1,7,1); then (0,2,2,2) (4,2,6,2); then (0,4,4,4).
  - Bank sequence 0,0,0,0,1,1,0. done pulses once and result_bank=1.
- N=5: commands (0,1,1,1) (2,1,3,1) (4,1,5,0); (0,2,2,2) (4,1,5,0); (0,4,4,1). result_bank=1, pass_idx reaches 3.
- N=0 and N=1: done 1 cycle after start, zero cmd_valid cycles, result_bank=0.
- cmd_ready held 0 for 5 cycles in ISSUE:
  - cmd_valid and fields stay stable.
  - A merge_done pulse injected in ISSUE is ignored.
  - Handshake completes on the first cycle with cmd_ready=1.
- abort asserted in WAIT during pass 1 of N=16: IDLE next cycle, busy=0, no done, result_bank unchanged. A following start with N=2 gives a single command (0,1,1,1) and result_bank=1.
- N=256 (ADDR_W=8) checks the boundary: last command (0,128,128,128), 8 passes, no base wrap. With MERGE_SCHED_PERF_EN defined, perf_cmds=255.
